execute_muldiv: RTL and testbench
=================================

# execute_muldiv

Iterative multiply/divide unit for the execute stage, implementing all eight RV M-extension operations for a parametrised `XLEN`. It sits beside the single-cycle ALU and consumes the already-forwarded operands. It stalls the pipeline while an operation is in flight, then presents the result for one cycle so the instruction can leave EX with it. Radix-2, one bit per cycle; divide-by-zero and signed overflow are short-circuited.

## Interface
- `XLEN`, 32: operand/result width; 32 and 64 supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level; EX holds a mul/div instruction; held high by the pipeline while stalled.
- `op`  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU;
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_value`  in  XLEN  forwarded rs1 (multiplicand / dividend).
- `rs2_value`  in  XLEN  forwarded rs2 (multiplier / divisor).
- `flush`  in  1  kill in-flight operation (branch taken / trap).
- `stall`  out  1  combinational; hold IF/ID/EX.
- `result_valid`  out  1  registered; result is valid this cycle.
- `result`  out  XLEN  registered result.

## Operation
- States:
  - IDLE: no operation in flight.
  - CALC: iterating; a 6-bit counter runs `XLEN`-1 down to 0.
  - DONE: result presented.
- IDLE + `start`:
  - latch `op` and the operand magnitudes;
  - record the result sign;
  - go to CALC, or directly to DONE if a special case applies.
- CALC:
  - one iteration per cycle;
  - leaves for DONE when the counter reaches 0, after exactly `XLEN` iterations.
- DONE:
  - `result_valid`=1; `start` is ignored because it is the same instruction;
  - next cycle always goes to IDLE.
- `stall` = (IDLE && `start` && !`flush`) || CALC; it is 0 in DONE.
- Multiply:
  - shift-add on a 2·XLEN accumulator using unsigned magnitudes;
  - the product is negated at the end if the result sign is set.
  - Operand signedness per op: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - restoring division on magnitudes;
  - quotient is negated if the operand signs differ (signed ops only);
  - remainder takes the sign of the dividend.
- Special cases, DONE one cycle after accept, no CALC:
  - divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV with dividend = −2^(XLEN−1) and divisor = −1: quotient = dividend, REM = 0.
- `flush`:
  - returns the unit to IDLE on the next edge; no `result_valid`;
  - `flush` has priority over `start` and over the CALC→DONE transition.
- Reset (`rst_n`=0 at an edge):
  - state IDLE, `result`=0, `result_valid`=0, counter 0;
  - `stall` is forced to 0 while `rst_n` is 0.
  - Applies mid-operation too; nothing survives.

## Timing
- Cycle 0: accept in IDLE, `stall`=1.
- Cycles 1..XLEN: CALC, `stall`=1.
- Cycle XLEN+1: DONE, `result_valid`=1, `stall`=0.
- Normal latency is XLEN+1 cycles from accept to result. Special cases take 1 cycle.
- Back-to-back: if `start` is high in the IDLE cycle after DONE, it is the next instruction and is accepted.
- Throughput: one operation per XLEN+2 cycles.
- `result` holds its value after DONE until the next DONE; consumers qualify it with `result_valid`.

## Structure
- Shared constants file:
  - `MULDIV_OP_BITS_COUNT` = 3;
  - the eight op encodings;
  - the state enum `muldiv_state_t` {IDLE, CALC, DONE}.
- Sub-module `muldiv_step`, combinational, parametrised by `XLEN`:
  - one shift-add or restore-subtract iteration on {acc, operand};
  - keeps the FSM/sign handling separate from the iteration datapath.

## Test plan
- XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD:
  - `stall` high cycles 0..32;
  - `result_valid` at cycle 33, `result`=0xFFFFFFEB.
- XLEN=32 high products:
  - MULH 0x80000000×0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- XLEN=32 signed divide of −7 by 2:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF;
  - DIVU 100/7 → 14; REMU → 2.
- XLEN=32 special cases, `result_valid` at cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Flush and reset:
  - `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `result_valid`, next `start` accepted;
  - `rst_n`=0 mid-CALC → all outputs 0 next cycle.
- XLEN=64 and back-to-back:
  - MULHU 2^63×4 → 2; latency 65;
  - two consecutive MULs with `start` held continuously → results at cycles 33 and 67, the second accepted at cycle 34.

Source files
------------

// File: rtl/execute_muldiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: op encodings
// (RV M-extension funct3) and the control state enum.
package execute_muldiv_pkg;

  localparam int MULDIV_OP_BITS_COUNT = 3;

  typedef enum logic [MULDIV_OP_BITS_COUNT-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

  // Bit 2 of funct3 separates the divide group from the multiply group.
  function automatic logic op_is_div(muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// Pipeline <-> multiply/divide unit connection. The pipeline (master) issues
// the instruction and flush; the unit (slave) returns stall and the result.
interface execute_muldiv_if #(parameter int XLEN = 32);
  import execute_muldiv_pkg::*;

  logic            start;
  muldiv_op_t      op;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1_value, rs2_value, flush,
    input  stall, result_valid, result
  );

  modport slave (
    input  start, op, rs1_value, rs2_value, flush,
    output stall, result_valid, result
  );

endinterface

// File: rtl/execute_muldiv_step.sv
// One radix-2 iteration on the {acc_hi, acc_lo} register pair.
// Multiply: acc_lo holds the remaining multiplier bits, acc_hi the partial
// product; add the multiplicand when the LSB is set, then shift right.
// Divide: acc_lo holds the remaining dividend bits, acc_hi the partial
// remainder; shift left, trial-subtract the divisor, keep it if it fits and
// shift the quotient bit in at the bottom.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  // Both candidate iterations are formed; the op selects which one is kept.
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // The shifted remainder may need XLEN+1 bits before the subtract.
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, operand_i};
    fits   = (rem_sh >= {1'b0, operand_i});
    if (is_div_i) begin
      acc_o = {(fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], fits};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV M-extension multiply/divide unit for the execute stage.
// Operands are converted to magnitudes at accept, iterated XLEN times by
// muldiv_step, and the sign is reapplied when the result is registered.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  execute_muldiv_if.slave   mdu
);

  localparam int W2 = 2 * XLEN;

  muldiv_state_t   state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  muldiv_op_t      op_q, op_d;
  logic            neg_q, neg_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;

  logic            s1, s2, a_neg, b_neg, sign_in, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_val, final_val;
  logic [W2-1:0]   step_acc, prod_s;
  logic [XLEN-1:0] quo, rem;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i  (op_is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc)
  );

  // Accept-time decode: operand signedness, magnitudes, result sign, special cases.
  always_comb begin
    s1       = (mdu.op == OP_MULH) || (mdu.op == OP_MULHSU) ||
               (mdu.op == OP_DIV)  || (mdu.op == OP_REM);
    s2       = (mdu.op == OP_MULH) || (mdu.op == OP_DIV) || (mdu.op == OP_REM);
    a_neg    = s1 && mdu.rs1_value[XLEN-1];
    b_neg    = s2 && mdu.rs2_value[XLEN-1];
    a_mag    = a_neg ? -mdu.rs1_value : mdu.rs1_value;
    b_mag    = b_neg ? -mdu.rs2_value : mdu.rs2_value;
    // Remainder follows the dividend; product and quotient follow the XOR.
    sign_in  = (mdu.op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = op_is_div(mdu.op) && (mdu.rs2_value == '0);
    div_ovf  = ((mdu.op == OP_DIV) || (mdu.op == OP_REM)) &&
               (mdu.rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.rs2_value == '1);
    if (div_zero) begin
      special_val = ((mdu.op == OP_DIV) || (mdu.op == OP_DIVU)) ? '1 : mdu.rs1_value;
    end else begin
      special_val = (mdu.op == OP_DIV) ? mdu.rs1_value : '0;
    end
  end

  // Final result from the last iteration's accumulator, with sign restored.
  always_comb begin
    prod_s = neg_q ? -step_acc : step_acc;
    quo    = step_acc[XLEN-1:0];
    rem    = step_acc[W2-1:XLEN];
    case (op_q)
      OP_MUL:                       final_val = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod_s[W2-1:XLEN];
      OP_DIV, OP_DIVU:              final_val = neg_q ? -quo : quo;
      default:                      final_val = neg_q ? -rem : rem;
    endcase
  end

  // Next-state and datapath load/iterate control.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    case (state_q)
      IDLE: begin
        if (mdu.start && !mdu.flush) begin
          op_d  = mdu.op;
          neg_d = sign_in;
          if (div_zero || div_ovf) begin
            result_d = special_val;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            acc_d   = op_is_div(mdu.op) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opnd_d  = op_is_div(mdu.op) ? b_mag : a_mag;
            cnt_d   = 6'(XLEN - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (cnt_q == '0) begin
          result_d = final_val;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A kill wins over accept and over completion; the old result is kept.
    if (mdu.flush) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  // Control state and visible outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Datapath registers; always reloaded at accept before being consumed.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; these are never read before an accept loads them.
    op_q   <= op_d;
    neg_q  <= neg_d;
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
  end

  assign mdu.stall        = rst_n && (((state_q == IDLE) && mdu.start && !mdu.flush) ||
                                      (state_q == CALC));
  assign mdu.result_valid = valid_q;
  assign mdu.result       = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: a 32-bit and a 64-bit instance on a shared clock.
// Stimulus pushes expected {value, due cycle} into a per-instance queue; a
// monitor pops and compares whenever result_valid is seen.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

  typedef struct {
    logic [63:0] val;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  execute_muldiv_if #(.XLEN(32)) if32 ();
  execute_muldiv_if #(.XLEN(64)) if64 ();

  execute_muldiv #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .mdu(if32));
  execute_muldiv #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .mdu(if64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (if32.result_valid) begin
      if (q32.size() == 0) fail_now("dut32 unexpected result_valid");
      else begin
        e32 = q32.pop_front();
        check({e32.name, " value"}, 64'(if32.result), e32.val);
        check({e32.name, " cycle"}, 64'(cyc), 64'(e32.due));
      end
    end
  end

  always @(negedge clk) begin
    if (if64.result_valid) begin
      if (q64.size() == 0) fail_now("dut64 unexpected result_valid");
      else begin
        e64 = q64.pop_front();
        check({e64.name, " value"}, if64.result, e64.val);
        check({e64.name, " cycle"}, 64'(cyc), 64'(e64.due));
      end
    end
  end

  task automatic drive(input bit w64, input logic st, input muldiv_op_t op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w64) begin
      if64.start = st; if64.op = op; if64.rs1_value = a; if64.rs2_value = b;
    end else begin
      if32.start = st; if32.op = op; if32.rs1_value = a[31:0]; if32.rs2_value = b[31:0];
    end
  endtask

  // Issue one op, count stall cycles until the result appears, then release start.
  task automatic run_op(input bit w64, input muldiv_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        input string name);
    int  stall_cnt = 0;
    bit  seen = 0;
    exp_t e;
    @(posedge clk); #1;
    drive(w64, 1'b1, op, a, b);
    e.val = exp; e.due = cyc + lat; e.name = name;
    if (w64) q64.push_back(e); else q32.push_back(e);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (w64 ? if64.stall : if32.stall) stall_cnt++;
      if (w64 ? if64.result_valid : if32.result_valid) seen = 1;
    end
    if (!seen) fail_now({name, " timeout"});
    else begin
      check({name, " stall in DONE"}, 64'(w64 ? if64.stall : if32.stall), 64'd0);
      check({name, " stall cycles"}, 64'(stall_cnt), 64'(lat));
    end
    drive(w64, 1'b0, OP_MUL, 64'd0, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int nv;
    bit seen;
    drive(1'b0, 1'b0, OP_MUL, 64'd0, 64'd0);
    drive(1'b1, 1'b0, OP_MUL, 64'd0, 64'd0);
    if32.flush = 1'b0;
    if64.flush = 1'b0;

    // Reset state; start is high so the forced-low stall is exercised.
    repeat (3) @(posedge clk);
    #1 if32.start = 1'b1;
    @(negedge clk);
    check("reset stall", 64'(if32.stall), 64'd0);
    check("reset valid", 64'(if32.result_valid), 64'd0);
    check("reset result", 64'(if32.result), 64'd0);
    check("reset result64", if64.result, 64'd0);
    if32.start = 1'b0;
    rst_n = 1'b1;

    // Main function, 32-bit.
    run_op(1'b0, OP_MUL,    64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB, 33, "MUL 7*-3");
    run_op(1'b0, OP_MULH,   64'h8000_0000,  64'h8000_0000, 64'h4000_0000, 33, "MULH");
    run_op(1'b0, OP_MULHU,  64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "MULHU");
    run_op(1'b0, OP_MULHSU, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 33, "MULHSU");
    run_op(1'b0, OP_DIV,    64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD, 33, "DIV -7/2");
    run_op(1'b0, OP_REM,    64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFF, 33, "REM -7/2");
    run_op(1'b0, OP_DIVU,   64'd100,        64'd7,         64'd14,        33, "DIVU 100/7");
    run_op(1'b0, OP_REMU,   64'd100,        64'd7,         64'd2,         33, "REMU 100/7");
    run_op(1'b0, OP_DIV,    64'd20,         64'hFFFF_FFFD, 64'hFFFF_FFFA, 33, "DIV 20/-3");
    run_op(1'b0, OP_REM,    64'd20,         64'hFFFF_FFFD, 64'd2,         33, "REM 20/-3");

    // Special cases: one cycle, no CALC.
    run_op(1'b0, OP_DIVU, 64'd5,         64'd0,         64'hFFFF_FFFF, 1, "DIVU 5/0");
    run_op(1'b0, OP_REM,  64'd5,         64'd0,         64'd5,         1, "REM 5/0");
    run_op(1'b0, OP_DIV,  64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "DIV ovf");
    run_op(1'b0, OP_REM,  64'h8000_0000, 64'hFFFF_FFFF, 64'd0,         1, "REM ovf");

    // Flush at cycle 10 of a DIV: back to IDLE at cycle 11, no result.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_DIV, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    #1;
    if32.flush = 1'b1;
    if32.start = 1'b0;
    @(posedge clk); #1;
    if32.flush = 1'b0;
    @(negedge clk);
    check("flush idle stall", 64'(if32.stall), 64'd0);
    check("flush no valid", 64'(if32.result_valid), 64'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if32.result_valid) nv++;
    end
    check("flush valid count", 64'(nv), 64'd0);
    run_op(1'b0, OP_DIVU, 64'd100, 64'd7, 64'd14, 33, "DIVU after flush");

    // Reset mid-CALC: everything visible drops to zero on the next cycle.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_MUL, 64'h1234, 64'h10);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset stall", 64'(if32.stall), 64'd0);
    check("midreset valid", 64'(if32.result_valid), 64'd0);
    check("midreset result", 64'(if32.result), 64'd0);
    if32.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    if32.start = 1'b1;
    #1;
    check("postreset accepts", 64'(if32.stall), 64'd1);
    if32.start = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if32.result_valid) nv++;
    end
    check("midreset valid count", 64'(nv), 64'd0);

    // 64-bit high product.
    run_op(1'b1, OP_MULHU, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65, "MULHU64");

    // Back-to-back with start held: results at cycles 33 and 67.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_MUL, 64'd3, 64'd5);
    c0 = cyc;
    e32.val = 64'd15;        e32.due = c0 + 33; e32.name = "b2b first";  q32.push_back(e32);
    e32.val = 64'h0123_4500; e32.due = c0 + 67; e32.name = "b2b second"; q32.push_back(e32);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (if32.result_valid) seen = 1;
    end
    if (!seen) fail_now("b2b first timeout");
    if32.rs1_value = 32'h0001_2345;
    if32.rs2_value = 32'h0000_0100;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (if32.result_valid) seen = 1;
    end
    if (!seen) fail_now("b2b second timeout");
    if32.start = 1'b0;

    repeat (5) @(posedge clk);
    check("q32 drained", 64'(q32.size()), 64'd0);
    check("q64 drained", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
